// File: rtl/hex_digit_driver_if.sv
// Processor-to-display bus: write request in, busy and committed digit codes out.
interface hex_digit_driver_if;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        dec_mode;
    logic        blank_lz;
    logic        busy;
    logic [19:0] digits;
    logic [4:0]  digit_blank;

    modport master (
        output wr_en, wr_data, dec_mode, blank_lz,
        input  busy, digits, digit_blank
    );

    modport slave (
        input  wr_en, wr_data, dec_mode, blank_lz,
        output busy, digits, digit_blank
    );
endinterface

// File: rtl/hex_digit_driver.sv
// Captures a 16-bit value and presents five hex or decimal digit codes with blank flags;
// decimal conversion is sequential shift-and-add-3, and outputs change only on commit.
module hex_digit_driver (
    input  logic                 clk,
    input  logic                 reset,
    hex_digit_driver_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    state_t      state, state_n;
    logic [15:0] bin_q, bin_n;
    logic [19:0] bcd_q, bcd_n;
    logic [19:0] bcd_adj;
    logic [3:0]  step_q, step_n;
    logic        mode_q, mode_n;
    logic        blz_q, blz_n;
    logic [19:0] digits_q, digits_n;
    logic [4:0]  blank_q, blank_n;

    function automatic logic [19:0] add3(input logic [19:0] bcd);
        logic [19:0] r;
        r = bcd;
        for (int unsigned i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Hex shadows always carry zero in digit4, so one scan over digits 4..1 serves both
    // modes; hex then forces digit4 dark unconditionally.
    function automatic logic [4:0] blank_of(input logic [19:0] d, input logic dec, input logic blz);
        logic [4:0] b;
        logic       zero_above;
        b          = '0;
        zero_above = 1'b1;
        for (int unsigned i = 4; i >= 1; i--) begin
            zero_above = zero_above & (d[4*i +: 4] == 4'h0);
            b[i]       = blz & zero_above;
        end
        if (!dec)
            b[4] = 1'b1;
        return b;
    endfunction

    assign bcd_adj = add3(bcd_q);

    always_comb begin
        state_n  = state;
        bin_n    = bin_q;
        bcd_n    = bcd_q;
        step_n   = step_q;
        mode_n   = mode_q;
        blz_n    = blz_q;
        digits_n = digits_q;
        blank_n  = blank_q;
        case (state)
            IDLE: begin
                if (bus.wr_en) begin
                    mode_n = bus.dec_mode;
                    blz_n  = bus.blank_lz;
                    step_n = '0;
                    if (bus.dec_mode) begin
                        bin_n   = bus.wr_data;
                        bcd_n   = '0;
                        state_n = CONV;
                    end else begin
                        bin_n   = '0;
                        bcd_n   = {4'h0, bus.wr_data};
                        state_n = COMMIT;
                    end
                end
            end
            CONV: begin
                {bcd_n, bin_n} = {bcd_adj[18:0], bin_q, 1'b0};
                step_n         = step_q + 4'd1;
                if (step_q == 4'd15)
                    state_n = COMMIT;
            end
            COMMIT: begin
                digits_n = bcd_q;
                blank_n  = blank_of(bcd_q, mode_q, blz_q);
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            step_q   <= '0;
            mode_q   <= 1'b0;
            blz_q    <= 1'b0;
            digits_q <= '0;
            blank_q  <= 5'b10000;
        end else begin
            state    <= state_n;
            bin_q    <= bin_n;
            bcd_q    <= bcd_n;
            step_q   <= step_n;
            mode_q   <= mode_n;
            blz_q    <= blz_n;
            digits_q <= digits_n;
            blank_q  <= blank_n;
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.digits      = digits_q;
    assign bus.digit_blank = blank_q;

endmodule
